pipe_stage_reg: RTL

Parametrised, handshaked pipeline stage register: the generic successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB register blocks. It carries an arbitrary-width payload between two pipeline stages using valid/ready flow control. It also supports an optional skid entry, so backpressure does not create a combinational ready path. Synchronous flush turns the stage into a bubble holding the all-zero payload (NOP), and saturating counters record stall and bubble cycles for the debugger.

---
 rtl/cpu_types_pkg.sv | 6 +
 rtl/pipe_pkg.sv | 13 +
 rtl/pipe_stage_reg_if.sv | 26 ++
 rtl/sat_counter.sv | 22 ++
 rtl/pipe_stage_reg.sv | 115 +++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Core-wide scalar types shared by the pipeline blocks.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

endpackage

// File: rtl/pipe_pkg.sv
// Types shared by the generic pipeline stage register and its users.
package pipe_pkg;

    // Encoding doubles as the beat count: EMPTY=0, BUSY=1, FULL=2.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pstate_t;

    typedef logic [1:0] occ_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream and downstream handshake of one pipeline stage register.
interface pipe_stage_reg_if #(
    parameter int WIDTH = $bits(cpu_types_pkg::word_t)
);

    // A beat transfers on a rising edge where valid and ready are both 1.
    // A producer holds valid and data stable until that edge; ready may
    // change freely and never gates a valid that is already asserted.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with optional skid entry, flush to
// NOP and saturating stall/bubble counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = $bits(cpu_types_pkg::word_t),
    parameter int SKID  = 1,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             flush,
    input  logic             cnt_clr,
    pipe_stage_reg_if.slave  bus,
    output occ_t             occupancy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output pstate_t          dbg_state
);

    typedef logic [WIDTH-1:0] data_t;

    pstate_t state_q, state_d;
    data_t   main_q, main_d;
    data_t   skid_q, skid_d;
    logic    in_ready;
    logic    out_valid;
    logic    in_fire;
    logic    out_fire;

    // With a skid entry, ready comes from registered state only.
    always_comb begin
        if (SKID != 0) begin
            in_ready = (state_q != FULL);
        end else begin
            in_ready = (state_q == EMPTY) || bus.out_ready;
        end
    end

    assign out_valid = (state_q != EMPTY);
    assign in_fire   = bus.in_valid & in_ready;
    assign out_fire  = out_valid & bus.out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = BUSY;
                        main_d  = bus.in_data;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_d = bus.in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end else if (in_fire && (SKID != 0)) begin
                        state_d = FULL;
                        skid_d  = bus.in_data;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_d = BUSY;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = main_q;
    assign occupancy     = occ_t'(state_q);
    assign dbg_state     = state_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK  (CLK),
        .nRST (nRST),
        .inc  (out_valid & ~bus.out_ready),
        .clr  (cnt_clr),
        .q    (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .CLK  (CLK),
        .nRST (nRST),
        .inc  (~out_valid & bus.out_ready),
        .clr  (cnt_clr),
        .q    (bubble_cnt)
    );

endmodule
